// File: rtl/sdram_burst_writer_pkg.sv
// sdram_wr_pkg: drain FSM encoding and frame/slot address helpers
package sdram_wr_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} wr_state_t;
  function automatic int frame_words(int w, int h);
    return w * h;
  endfunction
  function automatic int clog2_min1(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int slot_base(int base, int slot, int words);
    return base + slot * words;
  endfunction
endpackage

// File: rtl/sdram_burst_writer_if.sv
// sdram_burst_writer_if: pixel input and SDRAM write-burst handshake bundle
interface sdram_burst_writer_if #(
  parameter int PIXEL_W = 16,
  parameter int ADDR_W = 24
);
  logic i_pix_valid;
  logic [PIXEL_W-1:0] i_pix;
  logic o_pix_ready;
  logic o_wr_req;
  logic i_wr_ack;
  logic i_wr_next;
  logic [ADDR_W-1:0] o_sdram_addr;
  logic [PIXEL_W-1:0] o_sdram_pixel;
  logic o_bursting;
  modport slave (
    input i_pix_valid, i_pix, i_wr_ack, i_wr_next,
    output o_pix_ready, o_wr_req, o_sdram_addr, o_sdram_pixel, o_bursting
  );
  modport master (
    output i_pix_valid, i_pix, i_wr_ack, i_wr_next,
    input o_pix_ready, o_wr_req, o_sdram_addr, o_sdram_pixel, o_bursting
  );
endinterface

// File: rtl/sdram_burst_writer_buf.sv
// burst_pingpong_buf: two BURST_LEN-word banks with per-bank full flags
module burst_pingpong_buf #(
  parameter int BURST_LEN = 8,
  parameter int PIXEL_W = 16,
  localparam int PW = $clog2(BURST_LEN)
) (
  input  logic CLK,
  input  logic RST,
  input  logic we,
  input  logic wbank,
  input  logic [PW-1:0] wptr,
  input  logic [PIXEL_W-1:0] wdata,
  input  logic set_full,
  input  logic clr_full,
  input  logic rbank,
  input  logic [PW-1:0] ridx,
  output logic [PIXEL_W-1:0] rdata,
  output logic [1:0] full
);
  logic [PIXEL_W-1:0] mem [2][BURST_LEN];
  assign rdata = mem[rbank][ridx];
  // store pixels; a freed bank is zeroed so a flushed partial burst drains zero padding
  always_ff @(posedge CLK) begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < BURST_LEN; i++)
        if (!RST || (clr_full && rbank == b[0])) mem[b][i] <= '0;
    if (RST && we) mem[wbank][wptr] <= wdata;
  end
  // full flags: set by the fill side, cleared when the drain side finishes
  always_ff @(posedge CLK)
    if (!RST) full <= '0;
    else full <= (full | ({1'b0, set_full} << wbank)) & ~({1'b0, clr_full} << rbank);
endmodule

// File: rtl/sdram_burst_writer.sv
// sdram_burst_writer: ping-pong SDRAM burst writer; SDRAM_WR_FLUSH_EN adds i_flush partial-burst flush
module sdram_burst_writer
  import sdram_wr_pkg::*;
#(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int BURST_LEN = 8,
  parameter int PIXEL_W = 16,
  parameter int ADDR_W = 24,
  parameter int NUM_FRAMES = 2,
  parameter int BASE_ADDR = 0
) (
  input  logic CLK,
  input  logic RST,
`ifdef SDRAM_WR_FLUSH_EN
  input  logic i_flush,
`endif
  sdram_burst_writer_if.slave bus,
  output logic [clog2_min1(NUM_FRAMES)-1:0] o_frame_idx,
  output logic o_frame_done,
  output logic o_busy_wr
);
  localparam int FW = frame_words(FRAME_W, FRAME_H);
  localparam int HW = clog2_min1(FW);
  localparam int SW = clog2_min1(NUM_FRAMES);
  localparam int PW = $clog2(BURST_LEN);
  localparam logic [PW-1:0] LAST = PW'(BURST_LEN - 1);
  wr_state_t state, state_d;
  logic fill_sel, drain_sel, accept, complete, wrap, done;
  logic [PW-1:0] fill_ptr, idx, idx_d;
  logic [HW-1:0] head;
  logic [SW-1:0] slot;
  logic [1:0] full;
  logic [PIXEL_W-1:0] rdata;
  assign bus.o_pix_ready = !full[fill_sel];
  assign accept = bus.i_pix_valid && bus.o_pix_ready;
  assign done = state == DONE;
  assign wrap = (int'(head) + BURST_LEN) == FW;
  assign bus.o_wr_req = state == REQ;
  assign bus.o_bursting = state == DATA;
  assign bus.o_sdram_addr = ADDR_W'(slot_base(BASE_ADDR, int'(slot), FW) + int'(head));
  assign o_frame_idx = slot;
  assign o_frame_done = done && wrap;
`ifdef SDRAM_WR_FLUSH_EN
  logic pend, flush_req;
  assign flush_req = i_flush || pend;
  assign complete = (accept && fill_ptr == LAST) || (flush_req && (accept || fill_ptr != '0));
  // a flush arriving while the fill bank is still occupied waits for it to free
  always_ff @(posedge CLK)
    pend <= RST && flush_req && full[fill_sel];
`else
  assign complete = accept && fill_ptr == LAST;
`endif
  burst_pingpong_buf #(.BURST_LEN(BURST_LEN), .PIXEL_W(PIXEL_W)) u_buf (
    .CLK(CLK), .RST(RST), .we(accept), .wbank(fill_sel), .wptr(fill_ptr), .wdata(bus.i_pix),
    .set_full(complete), .clr_full(done), .rbank(drain_sel), .ridx(idx_d), .rdata(rdata), .full(full)
  );
  // fill side: advance the write pointer, hand the bank over when it completes
  always_ff @(posedge CLK)
    if (!RST) begin
      fill_sel <= 1'b0;
      fill_ptr <= '0;
    end else if (complete) begin
      fill_sel <= !fill_sel;
      fill_ptr <= '0;
    end else if (accept) fill_ptr <= fill_ptr + 1'b1;
  // drain FSM next state and next word index
  always_comb begin
    state_d = IDLE;
    idx_d = '0;
    case (state)
      IDLE: state_d = full[drain_sel] ? REQ : IDLE;
      REQ: state_d = bus.i_wr_ack ? DATA : REQ;
      DATA: begin
        state_d = (bus.i_wr_next && idx == LAST) ? DONE : DATA;
        idx_d = bus.i_wr_next ? idx + 1'b1 : idx;
      end
      default: state_d = IDLE;
    endcase
  end
  // drain registers, frame position and registered word/busy outputs
  always_ff @(posedge CLK)
    if (!RST) begin
      state <= IDLE;
      idx <= '0;
      drain_sel <= 1'b0;
      head <= '0;
      slot <= '0;
      o_busy_wr <= 1'b0;
      bus.o_sdram_pixel <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      o_busy_wr <= |full || state != IDLE;
      bus.o_sdram_pixel <= rdata;
      if (done) begin
        drain_sel <= !drain_sel;
        head <= wrap ? '0 : head + HW'(BURST_LEN);
        if (wrap) slot <= slot == SW'(NUM_FRAMES - 1) ? '0 : slot + 1'b1;
      end
    end
endmodule

// File: tb/tb_sdram_burst_writer.sv
// tb_sdram_burst_writer: randomized directed bench against a pixel-queue/burst-address reference model
module tb_sdram_burst_writer;
  localparam int BL = 8, FW = 16, NF = 2, BASE = 0;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic o_frame_done, o_busy_wr;
  logic [0:0] o_frame_idx;
  sdram_burst_writer_if #(.PIXEL_W(16), .ADDR_W(24)) bus ();
`ifdef SDRAM_WR_FLUSH_EN
  logic flush = 1'b0;
`endif
  sdram_burst_writer #(
    .FRAME_W(4), .FRAME_H(4), .BURST_LEN(BL), .PIXEL_W(16), .ADDR_W(24), .NUM_FRAMES(NF), .BASE_ADDR(BASE)
  ) dut (
    .CLK(CLK),
    .RST(RST),
`ifdef SDRAM_WR_FLUSH_EN
    .i_flush(flush),
`endif
    .bus(bus.slave),
    .o_frame_idx(o_frame_idx),
    .o_frame_done(o_frame_done),
    .o_busy_wr(o_busy_wr)
  );
  always #5 CLK = ~CLK;

  int vectors = 0, errors = 0, bursts = 0, acc_cnt = 0, stalls = 0, fd_cnt = 0;
  logic [15:0] q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int exp_addr(int n);
    int pos;
    pos = n * BL;
    return BASE + ((pos / FW) % NF) * FW + pos % FW;
  endfunction

  task automatic push_val(logic [15:0] p);
    int w;
    w = 0;
    bus.i_pix_valid = 1'b1;
    bus.i_pix = p;
    while (bus.o_pix_ready !== 1'b1 && w < 200) begin
      tick();
      w++;
      stalls++;
    end
    chk("push_ready", bus.o_pix_ready, 1);
    q.push_back(p);
    acc_cnt++;
    tick();
    bus.i_pix_valid = 1'b0;
  endtask

  task automatic push(int n, int gap);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, gap)) tick();
      push_val(16'($urandom));
    end
  endtask

  task automatic serve(int ack_dly, int gap);
    int w;
    logic [15:0] e;
    w = 0;
    while (bus.o_wr_req !== 1'b1 && w < 300) begin
      tick();
      w++;
    end
    chk("wr_req", bus.o_wr_req, 1);
    chk("addr", bus.o_sdram_addr, exp_addr(bursts));
    repeat (ack_dly) tick();
    chk("req_held", bus.o_wr_req, 1);
    bus.i_wr_ack = 1'b1;
    tick();
    bus.i_wr_ack = 1'b0;
    for (int k = 0; k < BL; k++) begin
      repeat ($urandom_range(0, gap)) tick();
      e = q.size() > 0 ? q.pop_front() : 16'hxxxx;
      chk("bursting", bus.o_bursting, 1);
      chk("word", bus.o_sdram_pixel, e);
      bus.i_wr_next = 1'b1;
      tick();
      bus.i_wr_next = 1'b0;
    end
    bursts++;
    chk("frame_done", o_frame_done, 32'((bursts * BL) % FW == 0));
    if (o_frame_done === 1'b1) fd_cnt++;
    tick();
    chk("frame_idx", o_frame_idx, (bursts * BL / FW) % NF);
    chk("bursting_off", bus.o_bursting, 0);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    bus.i_pix_valid = 1'b0;
    bus.i_wr_ack = 1'b0;
    bus.i_wr_next = 1'b0;
    tick();
    chk("rst_wr_req", bus.o_wr_req, 0);
    chk("rst_bursting", bus.o_bursting, 0);
    chk("rst_ready", bus.o_pix_ready, 1);
    chk("rst_frame_idx", o_frame_idx, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_busy", o_busy_wr, 0);
    chk("rst_addr", bus.o_sdram_addr, 0);
    chk("rst_pixel", bus.o_sdram_pixel, 0);
    RST = 1'b1;
    q.delete();
    bursts = 0;
    acc_cnt = 0;
    stalls = 0;
    fd_cnt = 0;
  endtask

  initial begin
    int w;
    bus.i_pix = '0;
    // single burst of known words
    do_reset();
    for (int k = 1; k <= 8; k++) push_val(16'(k));
    tick();
    chk("busy_full", o_busy_wr, 1);
    serve(1, 1);
    repeat (2) tick();
    chk("busy_idle", o_busy_wr, 0);
    // back-to-back frame with immediate ack never stalls
    do_reset();
    fork
      push(16, 0);
      begin
        serve(0, 0);
        serve(0, 0);
      end
    join
    chk("no_stall", stalls, 0);
    chk("frame_done_once", fd_cnt, 1);
    // withheld ack: both banks fill, 17th pixel waits for the first burst
    do_reset();
    fork
      push(17, 0);
      begin
        repeat (40) tick();
        chk("both_full_ready", bus.o_pix_ready, 0);
        chk("accepted_16", acc_cnt, 16);
        chk("req_waiting", bus.o_wr_req, 1);
        serve(0, 1);
        serve(2, 1);
      end
    join
    push(7, 1);
    serve(1, 0);
    // three frames with random gaps and ack delays
    do_reset();
    fork
      push(48, 1);
      repeat (6) serve($urandom_range(0, 3), 1);
    join
    chk("three_frames_done", fd_cnt, 3);
    // reset in the middle of a burst
    do_reset();
    push(8, 0);
    w = 0;
    while (bus.o_wr_req !== 1'b1 && w < 300) begin
      tick();
      w++;
    end
    chk("mid_wr_req", bus.o_wr_req, 1);
    bus.i_wr_ack = 1'b1;
    tick();
    bus.i_wr_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mid_word", bus.o_sdram_pixel, q.pop_front());
      bus.i_wr_next = 1'b1;
      tick();
      bus.i_wr_next = 1'b0;
    end
    chk("mid_bursting", bus.o_bursting, 1);
    do_reset();
    push(8, 0);
    serve(0, 0);
`ifdef SDRAM_WR_FLUSH_EN
    // flush of a 3-pixel partial burst drains with zero padding
    do_reset();
    push(3, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) q.push_back(16'h0000);
    serve(0, 0);
    push(8, 0);
    serve(0, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
